// File: rtl/wbuf_reader_pkg.sv
// Shared definitions for the filter-window BRAM readers: FSM state
// encoding, default data/address widths and the accumulator width rule.
package wbuf_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } wbuf_state_t;

  localparam int DEF_DATA_SIZE = 12;
  localparam int DEF_ADDR_SIZE = 5;

  // A window holds at most 2^addr_size samples, so addr_size extra bits
  // make the running sum impossible to overflow.
  function automatic int sum_width(input int data_size, input int addr_size);
    return data_size + addr_size;
  endfunction

endpackage

// File: rtl/wbuf_reader_rd_lat_delay.sv
// rd_lat_delay: loadable down-counter covering a BRAM read latency.
// Loaded in the read-enable cycle; capture is high in the last cycle of
// the wait, which is the cycle the BRAM data is valid on its output.
module rd_lat_delay
  #(parameter int RD_LAT = 1)
  (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic capture
  );

  localparam int CW = $clog2(RD_LAT + 1);

  logic [CW-1:0] cnt;

  // Latency counter: load with RD_LAT, then count down to zero and park.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(RD_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign capture = (cnt == CW'(1));

endmodule

// File: rtl/wbuf_reader.sv
// wbuf_reader: fetches an M-sample window from BRAM addresses 0..M-1 and
// streams it downstream on a valid/ready handshake, flagging the final
// sample with dlast and pulsing done when it transfers.
// Optional feature macro: WBUF_READER_SUM_EN adds a window accumulator
// (sum / sum_valid ports).
//
// Handshake: dout/dlast are held stable while dvalid is high; a sample
// moves only in a cycle with dvalid & dready both high. dready may rise
// before dvalid. The internal signal `state` carries the FSM state.
module wbuf_reader
  import wbuf_reader_pkg::*;
  #(
    parameter int M         = 4,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int RD_LAT    = 1
  )
  (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] di,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 en,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dvalid,
    input  logic                 dready,
    output logic                 dlast,
    output logic                 busy,
    output logic                 done
`ifdef WBUF_READER_SUM_EN
    ,
    output logic [sum_width(DATA_SIZE, ADDR_SIZE)-1:0] sum,
    output logic                                       sum_valid
`endif
  );

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(M - 1);

  wbuf_state_t          state;
  wbuf_state_t          state_next;
  logic [ADDR_SIZE-1:0] idx;
  logic [ADDR_SIZE-1:0] idx_next;
  logic                 lat_load;
  logic                 capture;
  logic                 xfer;

  rd_lat_delay #(.RD_LAT(RD_LAT)) u_rd_lat_delay (
    .clk     (clk),
    .rst     (rst),
    .load    (lat_load),
    .capture (capture)
  );

  // Next-state and sample index; the latency counter is armed in READ.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    lat_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_next   = '0;
          state_next = S_READ;
        end
      end
      S_READ: begin
        lat_load   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (capture) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (dready) begin
          if (idx == LAST_IDX) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = idx + ADDR_SIZE'(1);
            state_next = S_READ;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and index registers; reset aborts any window in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Output sample register, loaded only in the cycle the BRAM word is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if ((state == S_WAIT) && capture) begin
      dout <= di;
    end
  end

  // idx only changes on a transfer, so addr stays put outside READ.
  assign addr   = idx;
  assign en     = (state == S_READ);
  assign dvalid = (state == S_HOLD);
  assign dlast  = (state == S_HOLD) && (idx == LAST_IDX);
  assign busy   = (state != S_IDLE);
  assign xfer   = (state == S_HOLD) && dready;
  assign done   = xfer && (idx == LAST_IDX);

`ifdef WBUF_READER_SUM_EN
  localparam int SW = sum_width(DATA_SIZE, ADDR_SIZE);

  logic [SW-1:0] acc;

  // Window accumulator: cleared on an accepted start, adds each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if ((state == S_IDLE) && start) begin
      acc <= '0;
    end else if (xfer) begin
      acc <= acc + SW'(dout);
    end
  end

  // Fold the sample transferring this cycle in so that the total is
  // already complete in the done cycle.
  assign sum       = xfer ? (acc + SW'(dout)) : acc;
  assign sum_valid = done;
`endif

endmodule

// File: doc/wbuf_reader.md
# wbuf_reader

Read-side engine for a filter-window BRAM. On `start`, it fetches the M-sample window from BRAM addresses 0..M-1 in order, accounting for a configurable read latency. It then streams each sample downstream on a valid/ready handshake and marks the final sample with `dlast`. It sits between the window BRAM and the filter arithmetic in the filters IP.

## Interface
- `M`, 4: window length in samples (addresses 0..M-1); 1 ≤ M ≤ 2^ADDR_SIZE
- `ADDR_SIZE`, 5: BRAM address width
- `DATA_SIZE`, 12: sample width (unsigned)
- `RD_LAT`, 1: BRAM read latency in cycles, ≥ 1
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a window read; sampled only in IDLE
- `di`  in  DATA_SIZE  BRAM read data, valid RD_LAT cycles after the `en` cycle
- `addr`  out  ADDR_SIZE  BRAM read address
- `en`  out  1  BRAM read enable, one-cycle pulse per sample
- `dout`  out  DATA_SIZE  sample to downstream, held stable while `dvalid`=1
- `dvalid`  out  1  `dout` valid
- `dready`  in  1  downstream accepts; transfer = `dvalid & dready`
- `dlast`  out  1  high with `dvalid` on sample M-1
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse in the cycle the last sample transfers

## Operation
- FSM states: S_IDLE, S_READ, S_WAIT, S_HOLD.
- S_IDLE:
  - `start`=1 → S_READ with idx=0.
  - `start`=0 → stay.
- S_READ: `en`=1, `addr`=idx, one cycle → S_WAIT.
- S_WAIT:
  - Lasts exactly RD_LAT cycles, counted by the latency counter.
  - In the final WAIT cycle, `di` is registered into `dout` → S_HOLD.
- S_HOLD: `dvalid`=1.
  - No transfer → stay, with `dout` and `addr` stable.
  - Transfer with idx<M-1 → idx+1, S_READ.
  - Transfer with idx=M-1 → `done`=1 in that cycle, → S_IDLE.
- `dlast` = (state==S_HOLD) & (idx==M-1).
- `addr` holds its last value outside S_READ. `en` is 0 outside S_READ.
- `start` while `busy` is ignored. It is neither queued nor does it restart the read.
- `dready` may be high before `dvalid`. The transfer then completes in the first S_HOLD cycle.
- `rst` at any time, including mid-window, forces S_IDLE and aborts the window. No `done` is issued for an aborted window.
- Reset values:
  - `addr`=0, `en`=0, `dout`=0, `dvalid`=0, `dlast`=0, `busy`=0, `done`=0.
  - idx=0, latency counter=0.
  - With WBUF_READER_SUM_EN: `sum`=0, `sum_valid`=0.

## Timing
- Start is sampled at edge E0. The timing below is relative to E0:
  - `en` is high in the cycle after E0.
  - `dvalid` first rises RD_LAT+1 cycles after the `en` cycle, i.e. RD_LAT+2 cycles after E0.
- Per-sample period is RD_LAT+2 cycles, with `dready` held high.
- Full window with `dready`=1 takes M·(RD_LAT+2) cycles from E0 to `done`. For M=4 and RD_LAT=1, `done` is high in cycle 12 after E0.
- With `dready` held low, the block stalls indefinitely in S_HOLD. No further BRAM reads are issued.
- Back-to-back windows: `start` is accepted in the cycle after `done`, at the earliest.

## Configuration
- Macro `WBUF_READER_SUM_EN`.
- Defined: adds two output ports:
  - `sum` (DATA_SIZE+ADDR_SIZE bits): an unsigned accumulator.
  - `sum_valid` (1 bit).
- Accumulator behaviour:
  - Cleared when `start` is accepted.
  - Adds `dout` on every transfer.
  - `sum_valid` pulses with `done`; `sum` then holds the full-window total until the next accepted `start`.
  - No overflow is possible, since M ≤ 2^ADDR_SIZE.
- Undefined: the ports and accumulator are absent. Handshake behaviour and timing are identical in both builds.

## Structure
- Shared filters package holds:
  - State encoding constants S_IDLE, S_READ, S_WAIT, S_HOLD (2 bits).
  - Default DATA_SIZE and ADDR_SIZE.
  - The sum width expression.
- One sub-module, `rd_lat_delay`:
  - Loadable down-counter sized for RD_LAT.
  - Outputs a capture strobe in the final WAIT cycle.
  - Reused by other BRAM-reading blocks.

## Test plan
- Reset then idle, M=4, RD_LAT=1: all outputs 0; `start` pulse → `en` pulses at addr 0,1,2,3. Each `dout` equals the BRAM content, e.g. 0x00A,0x00B,0x00C,0x00D. `dlast` is set only with 0x00D; `done` is high at cycle 12.
- Backpressure: hold `dready`=0 for 5 cycles on sample 1 → `dout`/`addr` stable, no `en` during the stall. Release → sample 2 read follows with normal timing.
- RD_LAT=3: `dvalid` rises 5 cycles after E0. `dout` equals the BRAM word, not stale `di`.
- `start` asserted during a window and in the `done` cycle → ignored; `start` in the next cycle → new window at addr 0.
- `rst` asserted on sample 2 in S_HOLD → next cycle all outputs 0, `busy`=0, no `done`; next `start` reads from addr 0.
- With WBUF_READER_SUM_EN, samples 0xFFF×4 → `sum`=0x3FFC with `sum_valid` coincident with `done`; next `start` clears `sum` to 0.
